dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder that services load/store requests issued by the MEM pipeline stage. Holds a word-addressed 32-bit data array and answers each request after a fixed access latency. Uses a valid/ready request channel and a valid/ready response channel, plus a stall output that the pipeline uses to freeze the MEM stage. Sits between the MEM stage and the data array; it replaces the single-cycle combinational memory path.

## Interface
Parameters:
- DEPTH, 2048, number of 32-bit words; power of two.
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  store byte enables; bit i selects byte i (bits [8i+7:8i]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  load data.
- rsp_err  output  1  request was misaligned or out of range.
- stall  output  1  MEM stage must hold.

## Operation
- State machine with states IDLE, BUSY, RESP.
- IDLE: req_ready=1. When req_valid=1, latch we/addr/wdata/be at the edge, load cnt<=LATENCY-1, and go to BUSY.
- BUSY: req_ready=0. If cnt!=0, decrement cnt. If cnt==0, perform the access, set rsp_valid<=1, and go to RESP.
- RESP: req_ready=0 and rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready=1. At that edge, rsp_valid<=0 and the state returns to IDLE.
- Address decode: word index = addr[log2(DEPTH)+1:2].
  - err = (addr[1:0]!=0) OR (addr[31:log2(DEPTH)+2]!=0).
- Load: rsp_rdata = mem[index]; req_be is ignored.
- Store: each byte with be[i]=1 is written and the others are left untouched; rsp_rdata = 0.
- Any request with err=1 does not modify memory and returns rsp_rdata=0 with rsp_err=1.
- A store with be=4'b0000 is legal: no memory change, err=0.
- stall = (state!=IDLE) OR (req_valid AND NOT req_ready). This is combinational.
- Only one request is outstanding at a time. There is no pipelining of requests.

## Timing
- Reset (reset=0 at an edge): state<=IDLE, cnt<=0, rsp_valid<=0, rsp_rdata<=0, rsp_err<=0, latched request<=0. After reset, req_ready=1.
- Reset does not clear the memory array. Contents are preserved across reset.
- Reset mid-operation (in BUSY or RESP) aborts the request. A store that has not yet reached the BUSY cnt==0 edge is never written.
- Latency: request accepted at edge k; rsp_valid is first seen high after edge k+LATENCY. The store commits at that same edge k+LATENCY.
- rsp_ready already high when rsp_valid rises: the handshake completes at edge k+LATENCY+1, and IDLE is reached after that edge.
- Throughput: with rsp_ready held high, one request per LATENCY+2 cycles. The next request is accepted at the edge after IDLE is re-entered.
- Inputs req_* are sampled only at the acceptance edge. Later changes while in BUSY or RESP have no effect.
- rsp_ready is ignored outside RESP.
- rsp_valid, rsp_rdata and rsp_err are registered outputs. req_ready and stall are combinational from state and req_valid.

## Test plan
- Reset then idle: hold reset=0 for 2 cycles, release -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=0.
- Store/load, LATENCY=2:
  - Store addr=0x10, wdata=0xDEADBEEF, be=4'hF, accepted at edge k -> rsp_valid high after edge k+2, rsp_err=0, stall=1 from cycle k until the handshake.
  - Then load addr=0x10 -> rsp_rdata=0xDEADBEEF.
- Byte enables: word 0x10 = 0xDEADBEEF; store wdata=0x11223344, be=4'b0101 -> a following load returns 0xDE22BE44.
- Errors:
  - Load addr=0x13 (misaligned) -> rsp_err=1, rsp_rdata=0.
  - Store addr=0x2000 with DEPTH=2048 -> rsp_err=1, and word 0 is unchanged on a later load.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout. rsp_ready=1 -> IDLE on the next edge.
- Reset mid-store: accept a store to 0x20 of 0xCAFEF00D with LATENCY=4, assert reset at edge k+2 -> rsp_valid never rises, and a later load of 0x20 returns its prior value.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word-addressed data memory behind valid/ready request and response channels.
module dmem_responder #(
   parameter int DEPTH   = 2048,
   parameter int LATENCY = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [3:0]  i_req_be,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic        o_stall
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t        r_state;
   logic [3:0]    r_cnt;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_be;
   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] w_idx;
   logic          w_err;
   logic          w_fire;
   assign w_idx       = r_addr[AW+1:2];
   assign w_err       = (r_addr[1:0] != 2'b00) || (r_addr[31:AW+2] != '0);
   assign w_fire      = i_reset && r_state == BUSY && r_cnt == 4'd0;
   assign o_req_ready = r_state == IDLE;
   assign o_stall     = r_state != IDLE || (i_req_valid && !o_req_ready);
   // The array has no reset so its contents survive a reset pulse.
   always_ff @(posedge i_clk)
      if (w_fire && r_we && !w_err)
         for (int b = 0; b < 4; b++)
            if (r_be[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         o_rsp_valid <= 1'b0;
         o_rsp_rdata <= '0;
         o_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE:
               if (i_req_valid) begin
                  r_we    <= i_req_we;
                  r_addr  <= i_req_addr;
                  r_wdata <= i_req_wdata;
                  r_be    <= i_req_be;
                  r_cnt   <= 4'(LATENCY - 1);
                  r_state <= BUSY;
               end
            BUSY:
               if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
               else begin
                  o_rsp_valid <= 1'b1;
                  o_rsp_err   <= w_err;
                  o_rsp_rdata <= (w_err || r_we) ? '0 : r_mem[w_idx];
                  r_state     <= RESP;
               end
            RESP:
               if (i_rsp_ready) begin
                  o_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random requests checked against a word-array reference model.
module tb_dmem_responder;
   localparam int DEPTH = 2048;
   localparam int LAT   = 2;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        rsp_ready = 1'b0;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        stall;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [DEPTH];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
      .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
      .o_rsp_err(rsp_err), .o_stall(stall)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full request/response; hold = cycles rsp_ready stays low after rsp_valid rises.
   task automatic xact(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold);
      logic        exp_err;
      logic [31:0] exp_rd;
      int          idx;
      exp_err = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
      idx     = exp_err ? 0 : int'(addr / 4);
      exp_rd  = (exp_err || we) ? 32'h0 : model[idx];
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      rsp_ready = (hold == 0);
      check("idle_ready", req_ready, 1);
      check("idle_stall", stall, 0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom;
      req_wdata = $urandom; req_be = 4'($urandom);
      repeat (LAT) begin
         check("busy_valid", rsp_valid, 0);
         check("busy_stall", stall, 1);
         check("busy_ready", req_ready, 0);
         @(negedge clk);
      end
      check("rsp_valid", rsp_valid, 1);
      check("rsp_err", rsp_err, exp_err);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_stall", stall, 1);
      repeat (hold) begin
         @(negedge clk);
         check("hold_valid", rsp_valid, 1);
         check("hold_rdata", rsp_rdata, exp_rd);
         check("hold_ready", req_ready, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("done_valid", rsp_valid, 0);
      check("done_ready", req_ready, 1);
      check("done_stall", stall, 0);
      rsp_ready = 1'b0;
      if (we && !exp_err)
         for (int b = 0; b < 4; b++)
            if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
   endtask

   initial begin
      logic [31:0] a;
      int          r;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_ready", req_ready, 1);
      check("rst_valid", rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_err", rsp_err, 0);
      check("rst_stall", stall, 0);
      for (int w = 0; w < 32; w++) xact(1'b1, 32'(w * 4), $urandom, 4'hF, 0);
      xact(1'b1, 32'h1FFC, $urandom, 4'hF, 0);
      xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
      xact(1'b0, 32'h10, 32'h0, 4'h0, 0);
      xact(1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
      xact(1'b0, 32'h10, 32'h0, 4'h0, 0);
      xact(1'b0, 32'h13, 32'h0, 4'h0, 0);
      xact(1'b1, 32'h2000, 32'hA5A5A5A5, 4'hF, 0);
      xact(1'b0, 32'h0, 32'h0, 4'h0, 0);
      xact(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0);
      xact(1'b0, 32'h10, 32'h0, 4'h0, 5);
      xact(1'b0, 32'h1FFC, 32'h0, 4'h0, 0);
      xact(1'b0, 32'h1FFE, 32'h0, 4'h0, 0);
      // Reset lands before the commit edge, so the store must be dropped.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("abort_ready", req_ready, 1);
      repeat (4) begin
         check("abort_valid", rsp_valid, 0);
         @(negedge clk);
      end
      xact(1'b0, 32'h20, 32'h0, 4'h0, 0);
      repeat (40) begin
         r = $urandom_range(0, 9);
         a = 32'($urandom_range(0, 31) * 4);
         if (r == 7) a = a + 32'($urandom_range(1, 3));
         else if (r == 8) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 1000) * 4);
         else if (r == 9) a = {1'b1, 31'($urandom)};
         xact(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
